// File: rtl/branch_ctrl_if.sv
// Branch-controller bus: frame position, ROM nibble stream and datapath flags in; PC/stack/ACC control out.
// Latency: none (wires only).
// Backpressure: none; the instruction frame is a fixed 8-cycle schedule.
//
// Ports (slave = branch_ctrl side):
//   cycle, romData, pcAddr, pairDout, stackTop, accZero, carry, testFlag, iszZero  -> controller
//   pcLoad, pcNew, stackPush, pushAddr, stackPop, accLoad, accData,
//   word2Active, branchTaken                                                       <- controller
interface branch_ctrl_if #(
    parameter int AW = 12
);
    logic [2:0]    cycle;
    logic [3:0]    romData;
    logic [AW-1:0] pcAddr;
    logic [7:0]    pairDout;
    logic [AW-1:0] stackTop;
    logic          accZero;
    logic          carry;
    logic          testFlag;
    logic          iszZero;

    logic          pcLoad;
    logic [AW-1:0] pcNew;
    logic          stackPush;
    logic [AW-1:0] pushAddr;
    logic          stackPop;
    logic          accLoad;
    logic [3:0]    accData;
    logic          word2Active;
    logic          branchTaken;

    modport master (
        output cycle, romData, pcAddr, pairDout, stackTop,
               accZero, carry, testFlag, iszZero,
        input  pcLoad, pcNew, stackPush, pushAddr, stackPop,
               accLoad, accData, word2Active, branchTaken
    );

    modport slave (
        input  cycle, romData, pcAddr, pairDout, stackTop,
               accZero, carry, testFlag, iszZero,
        output pcLoad, pcNew, stackPush, pushAddr, stackPop,
               accLoad, accData, word2Active, branchTaken
    );
endinterface

// File: rtl/branch_ctrl.sv
// PC-redirect sequencer for JUN/JMS/JCN/ISZ/JIN/BBL, plus FIM second-word flagging.
// Latency: control outputs registered on the cycle-6 edge, valid for the X3 cycle only.
// Backpressure: none; follows the fixed 8-cycle frame, pc/stack must accept every pulse.
//
// Ports:
//   clk, rstN      clock and asynchronous active-low reset
//   bus (slave)    frame position, ROM nibbles, PC, register pair, stack top and
//                  condition flags in; PC load/target, stack push/pop, ACC load,
//                  second-word flag and branch-taken debug out
module branch_ctrl #(
    parameter int         AW     = 12,
    parameter logic [2:0] CYC_M1 = 3'd3,
    parameter logic [2:0] CYC_M2 = 3'd4,
    parameter logic [2:0] CYC_X3 = 3'd7
) (
    input logic          clk,
    input logic          rstN,
    branch_ctrl_if.slave bus
);

    // Everything the controller drives is decided one edge before X3 so it is
    // stable for the whole X3 cycle, when pc/stack sample it.
    localparam logic [2:0] CYC_DEC = CYC_X3 - 3'd1;

    localparam logic [3:0] OP_JCN = 4'h1;
    localparam logic [3:0] OP_FIM = 4'h2;   // also SRC when opa[0]==1
    localparam logic [3:0] OP_JIN = 4'h3;   // also FIN when opa[0]==0
    localparam logic [3:0] OP_JUN = 4'h4;
    localparam logic [3:0] OP_JMS = 4'h5;
    localparam logic [3:0] OP_ISZ = 4'h7;
    localparam logic [3:0] OP_BBL = 4'hC;

    typedef enum logic {
        S_W1 = 1'b0,    // frame carries an opcode word
        S_W2 = 1'b1     // frame carries the second word of a two-word instruction
    } state_t;

    state_t        state_q, state_d;

    // First-word opcode, kept through the second word so it selects the action there.
    logic [3:0]    opr_q, opr_d;
    logic [3:0]    opa_q, opa_d;
    // Second-word nibbles and the address the second word was fetched from.
    logic [3:0]    opr2_q, opr2_d;
    logic [3:0]    opa2_q, opa2_d;
    logic [AW-1:0] w2_addr_q, w2_addr_d;
    // JCN/ISZ outcome, resolved during the first word.
    logic          cond_q, cond_d;

    logic          pc_load_q, pc_load_d;
    logic [AW-1:0] pc_new_q, pc_new_d;
    logic          stack_push_q, stack_push_d;
    logic [AW-1:0] push_addr_q, push_addr_d;
    logic          stack_pop_q, stack_pop_d;
    logic          acc_load_q, acc_load_d;
    logic [3:0]    acc_data_q, acc_data_d;
    logic          branch_taken_q, branch_taken_d;

    logic          two_word;
    logic          jcn_cond;
    logic [AW-9:0] pc_inc_page;
    logic [AW-1:0] w2_nxt;

    // Opcodes whose next frame is an operand word rather than an opcode.
    assign two_word = (opr_q == OP_JCN) ||
                      ((opr_q == OP_FIM) && !opa_q[0]) ||
                      (opr_q == OP_JUN) ||
                      (opr_q == OP_JMS) ||
                      (opr_q == OP_ISZ);

    // JCN: any enabled test true, then optionally inverted by opa[3].
    assign jcn_cond = ((opa_q[2] & bus.accZero) |
                       (opa_q[1] & bus.carry)   |
                       (opa_q[0] & ~bus.testFlag)) ^ opa_q[3];

    // Only the page of pcAddr+1 is needed for JIN; the page bumps when the
    // low byte is about to wrap (JIN at xFF lands in page x+1).
    assign pc_inc_page = bus.pcAddr[AW-1:8] + (AW-8)'(&bus.pcAddr[7:0]);

    // Address after the second word: JMS return address and JCN/ISZ page.
    assign w2_nxt = w2_addr_q + AW'(1);

    always_comb begin
        state_d        = state_q;
        opr_d          = opr_q;
        opa_d          = opa_q;
        opr2_d         = opr2_q;
        opa2_d         = opa2_q;
        w2_addr_d      = w2_addr_q;
        cond_d         = cond_q;
        // Outputs are single-cycle pulses: zero unless this is the decision edge.
        pc_load_d      = 1'b0;
        pc_new_d       = '0;
        stack_push_d   = 1'b0;
        push_addr_d    = '0;
        stack_pop_d    = 1'b0;
        acc_load_d     = 1'b0;
        acc_data_d     = 4'h0;
        branch_taken_d = 1'b0;

        case (state_q)
            S_W1: begin
                if (bus.cycle == CYC_M1) opr_d = bus.romData;
                if (bus.cycle == CYC_M2) opa_d = bus.romData;

                if (bus.cycle == CYC_DEC) begin
                    case (opr_q)
                        OP_JCN: cond_d = jcn_cond;
                        OP_ISZ: cond_d = ~bus.iszZero;
                        OP_JIN: begin
                            if (opa_q[0]) begin
                                pc_load_d = 1'b1;
                                pc_new_d  = {pc_inc_page, bus.pairDout};
                            end
                        end
                        OP_BBL: begin
                            pc_load_d   = 1'b1;
                            pc_new_d    = bus.stackTop;
                            stack_pop_d = 1'b1;
                            acc_load_d  = 1'b1;
                            acc_data_d  = opa_q;
                        end
                        default: ;
                    endcase
                end

                if ((bus.cycle == CYC_X3) && two_word) state_d = S_W2;
            end

            S_W2: begin
                // opr/opa are left alone here so a second word that happens to
                // look like an opcode is never decoded as one.
                if (bus.cycle == CYC_M1) begin
                    opr2_d    = bus.romData;
                    w2_addr_d = bus.pcAddr;
                end
                if (bus.cycle == CYC_M2) opa2_d = bus.romData;

                if (bus.cycle == CYC_DEC) begin
                    case (opr_q)
                        OP_JUN: begin
                            pc_load_d = 1'b1;
                            pc_new_d  = AW'({opa_q, opr2_q, opa2_q});
                        end
                        OP_JMS: begin
                            pc_load_d    = 1'b1;
                            pc_new_d     = AW'({opa_q, opr2_q, opa2_q});
                            stack_push_d = 1'b1;
                            push_addr_d  = w2_nxt;
                        end
                        OP_JCN, OP_ISZ: begin
                            // Short jumps stay in the page that follows the
                            // second word, so a word at xFF targets page x+1.
                            if (cond_q) begin
                                pc_load_d      = 1'b1;
                                pc_new_d       = {w2_nxt[AW-1:8], opr2_q, opa2_q};
                                branch_taken_d = 1'b1;
                            end
                        end
                        default: ;  // FIM: operand word only, no redirect
                    endcase
                end

                if (bus.cycle == CYC_X3) state_d = S_W1;
            end

            default: state_d = S_W1;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q        <= S_W1;
            opr_q          <= 4'h0;
            opa_q          <= 4'h0;
            opr2_q         <= 4'h0;
            opa2_q         <= 4'h0;
            w2_addr_q      <= '0;
            cond_q         <= 1'b0;
            pc_load_q      <= 1'b0;
            pc_new_q       <= '0;
            stack_push_q   <= 1'b0;
            push_addr_q    <= '0;
            stack_pop_q    <= 1'b0;
            acc_load_q     <= 1'b0;
            acc_data_q     <= 4'h0;
            branch_taken_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            opr_q          <= opr_d;
            opa_q          <= opa_d;
            opr2_q         <= opr2_d;
            opa2_q         <= opa2_d;
            w2_addr_q      <= w2_addr_d;
            cond_q         <= cond_d;
            pc_load_q      <= pc_load_d;
            pc_new_q       <= pc_new_d;
            stack_push_q   <= stack_push_d;
            push_addr_q    <= push_addr_d;
            stack_pop_q    <= stack_pop_d;
            acc_load_q     <= acc_load_d;
            acc_data_q     <= acc_data_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    assign bus.pcLoad      = pc_load_q;
    assign bus.pcNew       = pc_new_q;
    assign bus.stackPush   = stack_push_q;
    assign bus.pushAddr    = push_addr_q;
    assign bus.stackPop    = stack_pop_q;
    assign bus.accLoad     = acc_load_q;
    assign bus.accData     = acc_data_q;
    assign bus.branchTaken = branch_taken_q;
    // Registered state bit, so it is high for every cycle of a second-word frame.
    assign bus.word2Active = (state_q == S_W2);

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed instruction frames against an instruction-level model.
// Latency: expects control pulses exactly in cycle 7 of the relevant frame.
// Backpressure: none; frames are driven back to back.
module tb_branch_ctrl;

    logic clk;
    logic rstN;

    branch_ctrl_if #(.AW(12)) bus ();

    branch_ctrl #(.AW(12)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Instruction-level model state.
    bit         m_in_w2;
    logic [3:0] m_opr, m_opa;
    bit         m_jump;

    // What the current frame must show in its X3 cycle.
    logic        exp_pc_load, exp_push, exp_pop, exp_acc_load, exp_taken, exp_w2;
    logic [11:0] exp_pc_new, exp_push_addr;
    logic [3:0]  exp_acc_data;

    // DUT outputs captured in the X3 cycle of the most recent frame.
    logic        cap_pc_load, cap_push, cap_pop, cap_acc_load, cap_taken, cap_w2;
    logic [11:0] cap_pc_new, cap_push_addr;
    logic [3:0]  cap_acc_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic clear_exp();
        exp_pc_load = 0; exp_pc_new = 0; exp_push = 0; exp_push_addr = 0;
        exp_pop = 0; exp_acc_load = 0; exp_acc_data = 0; exp_taken = 0;
    endtask

    // Compare every cycle: pulses only in cycle 7, word2Active for the whole frame.
    always @(negedge clk) begin
        if (rstN && chk_en) begin
            if (bus.cycle == 3'd7) begin
                check("pcLoad",      32'(bus.pcLoad),      32'(exp_pc_load));
                check("pcNew",       32'(bus.pcNew),       32'(exp_pc_new));
                check("stackPush",   32'(bus.stackPush),   32'(exp_push));
                check("pushAddr",    32'(bus.pushAddr),    32'(exp_push_addr));
                check("stackPop",    32'(bus.stackPop),    32'(exp_pop));
                check("accLoad",     32'(bus.accLoad),     32'(exp_acc_load));
                check("accData",     32'(bus.accData),     32'(exp_acc_data));
                check("branchTaken", 32'(bus.branchTaken), 32'(exp_taken));
                cap_pc_load = bus.pcLoad;   cap_pc_new = bus.pcNew;
                cap_push = bus.stackPush;   cap_push_addr = bus.pushAddr;
                cap_pop = bus.stackPop;     cap_acc_load = bus.accLoad;
                cap_acc_data = bus.accData; cap_taken = bus.branchTaken;
                cap_w2 = bus.word2Active;
            end else begin
                check("idle_outputs",
                      32'({bus.pcLoad, bus.stackPush, bus.stackPop, bus.accLoad, bus.branchTaken}),
                      32'd0);
                check("idle_buses", 32'({bus.pcNew, bus.pushAddr, bus.accData}), 32'd0);
            end
            check("word2Active", 32'(bus.word2Active), 32'(exp_w2));
        end
    end

    // One 8-cycle frame. fl = {accZero, carry, testFlag, iszZero}.
    // rst_at >= 0 asserts reset in that cycle and releases it one cycle later.
    task automatic frame(input logic [3:0] opr, input logic [3:0] opa, input logic [11:0] pc,
                         input logic [7:0] pair, input logic [11:0] stk, input logic [3:0] fl,
                         input int rst_at);
        logic [11:0] nxt;
        logic [7:0]  byte2;
        bit t;
        clear_exp();
        exp_w2 = m_in_w2;
        if (!m_in_w2) begin
            if (opr == 4'h3 && opa[0]) begin                 // JIN
                nxt = pc + 12'd1;
                exp_pc_load = 1; exp_pc_new = (nxt & 12'hF00) | {4'h0, pair};
            end else if (opr == 4'hC) begin                  // BBL
                exp_pc_load = 1; exp_pc_new = stk; exp_pop = 1;
                exp_acc_load = 1; exp_acc_data = opa;
            end
            if (opr == 4'h1 || opr == 4'h4 || opr == 4'h5 || opr == 4'h7 ||
                (opr == 4'h2 && !opa[0])) begin
                m_in_w2 = 1; m_opr = opr; m_opa = opa;
                if (opr == 4'h1) begin
                    t = 0;
                    if (opa[2] && fl[3]) t = 1;
                    if (opa[1] && fl[2]) t = 1;
                    if (opa[0] && !fl[1]) t = 1;
                    m_jump = opa[3] ? !t : t;
                end else begin
                    m_jump = !fl[0];                         // ISZ: loop while nonzero
                end
            end
        end else begin
            nxt = pc + 12'd1;
            byte2 = {opr, opa};
            if (m_opr == 4'h4 || m_opr == 4'h5) begin
                exp_pc_load = 1; exp_pc_new = {m_opa, byte2};
                if (m_opr == 4'h5) begin exp_push = 1; exp_push_addr = nxt; end
            end else if ((m_opr == 4'h1 || m_opr == 4'h7) && m_jump) begin
                exp_pc_load = 1; exp_pc_new = (nxt & 12'hF00) | {4'h0, byte2}; exp_taken = 1;
            end
            m_in_w2 = 0;
        end

        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && c == rst_at + 1) rstN = 1'b1;
            bus.cycle    = 3'(c);
            bus.romData  = (c == 3) ? opr : (c == 4) ? opa : 4'(c * 3 + 8);
            bus.pcAddr   = pc;
            bus.pairDout = pair;
            bus.stackTop = stk;
            {bus.accZero, bus.carry, bus.testFlag, bus.iszZero} = fl;
            if (c == rst_at) begin
                rstN = 1'b0;
                m_in_w2 = 0; clear_exp(); exp_w2 = 0;
                #1;
                check("rst_word2Active", 32'(bus.word2Active), 32'd0);
                check("rst_outputs",
                      32'({bus.pcLoad, bus.stackPush, bus.stackPop, bus.accLoad, bus.branchTaken}),
                      32'd0);
            end
        end
        @(negedge clk); #1;
    endtask

    initial begin
        rstN = 1'b0;
        bus.cycle = 3'd0; bus.romData = 4'h0; bus.pcAddr = 12'h000;
        bus.pairDout = 8'h00; bus.stackTop = 12'h000;
        bus.accZero = 0; bus.carry = 0; bus.testFlag = 0; bus.iszZero = 0;
        m_in_w2 = 0; m_opr = 0; m_opa = 0; m_jump = 0;
        clear_exp(); exp_w2 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulses",
              32'({bus.pcLoad, bus.stackPush, bus.stackPop, bus.accLoad, bus.branchTaken, bus.word2Active}),
              32'd0);
        check("reset_buses", 32'({bus.pcNew, bus.pushAddr, bus.accData}), 32'd0);
        rstN = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // JUN 0x235 from 0x000
        frame(4'h4, 4'h2, 12'h000, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h3, 4'h5, 12'h001, 8'h00, 12'h000, 4'b0000, -1);
        check("t1_pcNew", 32'(cap_pc_new), 32'h235);
        check("t1_pcLoad_w2_push", 32'({cap_pc_load, cap_w2, cap_push}), 32'b110);

        // JMS 0x123 at 0x010, then BBL 7 returning to 0x012
        frame(4'h5, 4'h1, 12'h010, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h2, 4'h3, 12'h011, 8'h00, 12'h000, 4'b0000, -1);
        check("t2_pushAddr", 32'(cap_push_addr), 32'h012);
        check("t2_pcNew", 32'(cap_pc_new), 32'h123);
        frame(4'hC, 4'h7, 12'h123, 8'h00, 12'h012, 4'b0000, -1);
        check("t2_bbl", 32'({cap_pop, cap_acc_load, cap_acc_data, cap_pc_new}), 32'({2'b11, 4'h7, 12'h012}));

        // JCN on ACC==0: taken, not taken, inverted; flags flip during the second word
        frame(4'h1, 4'h4, 12'h200, 8'h00, 12'h000, 4'b1000, -1);
        frame(4'h4, 4'h0, 12'h201, 8'h00, 12'h000, 4'b0000, -1);
        check("t3_taken", 32'({cap_pc_load, cap_taken, cap_pc_new}), 32'({2'b11, 12'h240}));
        frame(4'h1, 4'h4, 12'h210, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h4, 4'h0, 12'h211, 8'h00, 12'h000, 4'b1000, -1);
        check("t3_not_taken", 32'(cap_pc_load), 32'd0);
        frame(4'h1, 4'hC, 12'h220, 8'h00, 12'h000, 4'b1000, -1);
        frame(4'h4, 4'h0, 12'h221, 8'h00, 12'h000, 4'b1000, -1);
        check("t3_inverted", 32'(cap_pc_load), 32'd0);
        frame(4'h1, 4'h2, 12'h230, 8'h00, 12'h000, 4'b0100, -1);   // carry
        frame(4'h5, 4'h5, 12'h231, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h1, 4'h1, 12'h240, 8'h00, 12'h000, 4'b0010, -1);   // TEST high: not taken
        frame(4'h6, 4'h6, 12'h241, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h1, 4'h9, 12'h250, 8'h00, 12'h000, 4'b0010, -1);   // inverted TEST: taken
        frame(4'h7, 4'h7, 12'h251, 8'h00, 12'h000, 4'b0000, -1);
        check("t3_test_inv", 32'(cap_pc_new), 32'h277);

        // Page crossing and 12-bit wrap, then ISZ both ways
        frame(4'h1, 4'h4, 12'h0FE, 8'h00, 12'h000, 4'b1000, -1);
        frame(4'h8, 4'h0, 12'h0FF, 8'h00, 12'h000, 4'b0000, -1);
        check("t4_page", 32'(cap_pc_new), 32'h180);
        frame(4'h1, 4'h2, 12'hFFE, 8'h00, 12'h000, 4'b0100, -1);
        frame(4'h1, 4'h2, 12'hFFF, 8'h00, 12'h000, 4'b0000, -1);
        check("t4_wrap", 32'(cap_pc_new), 32'h012);
        frame(4'h7, 4'h3, 12'h050, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h6, 4'h6, 12'h051, 8'h00, 12'h000, 4'b0001, -1);
        check("t4_isz_jump", 32'(cap_pc_new), 32'h066);
        frame(4'h7, 4'h3, 12'h060, 8'h00, 12'h000, 4'b0001, -1);
        frame(4'h6, 4'h6, 12'h061, 8'h00, 12'h000, 4'b0000, -1);
        check("t4_isz_fall", 32'(cap_pc_load), 32'd0);

        // JIN, FIM second word, SRC as single word, JIN at page end
        frame(4'h3, 4'h1, 12'h345, 8'h9A, 12'h000, 4'b0000, -1);
        check("t5_jin", 32'(cap_pc_new), 32'h39A);
        frame(4'h2, 4'h0, 12'h400, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h9, 4'h9, 12'h401, 8'h00, 12'h000, 4'b0000, -1);
        check("t5_fim", 32'({cap_w2, cap_pc_load}), 32'b10);
        frame(4'h2, 4'h1, 12'h402, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h3, 4'h1, 12'h403, 8'h55, 12'h000, 4'b0000, -1);
        check("t5_src_single", 32'({cap_w2, cap_pc_new}), 32'({1'b0, 12'h455}));

        // Reset in the middle of a JUN second word aborts it
        frame(4'h4, 4'h2, 12'h500, 8'h00, 12'h000, 4'b0000, -1);
        frame(4'h3, 4'h5, 12'h501, 8'h00, 12'h000, 4'b0000, 5);
        check("t6_no_pulse", 32'(cap_pc_load), 32'd0);
        frame(4'h3, 4'h1, 12'h3FF, 8'h12, 12'h000, 4'b0000, -1);
        check("t6_word1", 32'({cap_w2, cap_pc_load, cap_pc_new}), 32'({2'b01, 12'h412}));

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
